// File: rtl/whack_pkg.sv
// Shared definitions for the whack-a-mole judging path and the combo counter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the default geometry of the playfield and the encoding of a judge
// result. The combo counter and its bench decode the same encoding.
package whack_pkg;

  localparam int NUM_HOLES_DEF = 9;
  localparam int LIFE_W_DEF    = 26;
  localparam int IDX_W_DEF     = 4;

  // One judge verdict per cycle; the three pulse outputs are a one-hot
  // decode of this value, so they can never overlap.
  typedef enum logic [1:0] {
    RES_NONE = 2'd0,
    RES_MISS = 2'd1,
    RES_HIT  = 2'd2,
    RES_FULL = 2'd3
  } judge_res_e;

endpackage

// File: rtl/mole_life_timer.sv
// Lifetime countdown for a single hole.
// Latency: load/clear take effect at the next clk edge; expire is combinational from the count.
// Backpressure: none; clear beats load, load beats decrement.
//
// Ports:
//   clk, reset   system clock, synchronous active-low reset
//   clear        drop the count to 0 (hole hit or round not running)
//   load         start a new lifetime for this hole
//   life         requested lifetime in cycles; 0 is treated as 1
//   expire       high during the last live cycle (count == 1)
module mole_life_timer
  import whack_pkg::*;
#(
  parameter int LIFE_W = LIFE_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [LIFE_W-1:0] life,
  output logic              expire
);

  logic [LIFE_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      // A zero lifetime would leave the mole set with no counter to expire it.
      cnt <= (life == '0) ? LIFE_W'(1) : life;
    end else if (cnt != '0) begin
      cnt <= cnt - LIFE_W'(1);
    end
  end

  // The count stepping 1 -> 0 is the cycle the owning mask bit must drop.
  assign expire = (cnt == LIFE_W'(1));

endmodule

// File: rtl/mole_hit_judge.sv
// Judges hole-button presses against the active-mole mask and ages each mole.
// Latency: a btn rise sampled at edge k shows on the pulse outputs after edge k+3.
// Backpressure: none; pulses are single-cycle and the combo counter must take every one.
//
// Ports:
//   clk                 system clock
//   reset               synchronous active-low reset, wins over every other event
//   game_active         round running; low clears mask/timers and mutes judging
//   btn                 debounced hole buttons, asynchronous to clk
//   spawn_valid/idx     one-cycle request to raise the mole at hole idx
//   mole_life           lifetime in cycles for the spawned mole
//   mole_mask           registered active-mole mask
//   miss                press on an empty hole (or expiry, see below)
//   non_full_clear_hit  hit that leaves moles standing
//   full_clear_hit      hit that leaves the board empty
//
// Build option EXPIRE_MISS_EN: an expiring mole also counts as a miss. If the
// judge already emits a pulse that cycle, the miss is parked in a 1-bit flag
// and emitted on the next pulse-free cycle.
module mole_hit_judge
  import whack_pkg::*;
#(
  parameter int NUM_HOLES = NUM_HOLES_DEF,
  parameter int LIFE_W    = LIFE_W_DEF,
  parameter int IDX_W     = IDX_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 game_active,
  input  logic [NUM_HOLES-1:0] btn,
  input  logic                 spawn_valid,
  input  logic [IDX_W-1:0]     spawn_idx,
  input  logic [LIFE_W-1:0]    mole_life,
  output logic [NUM_HOLES-1:0] mole_mask,
  output logic                 miss,
  output logic                 non_full_clear_hit,
  output logic                 full_clear_hit
);

  // ---------------------------------------------------------------------
  // Button input path: 2-FF synchroniser, edge detector, registered press.
  // These keep tracking btn while the round is idle so a button held across
  // the start of a round is already "old" and does not fire.
  // ---------------------------------------------------------------------
  logic [NUM_HOLES-1:0] btn_s1;
  logic [NUM_HOLES-1:0] btn_s2;
  logic [NUM_HOLES-1:0] btn_s3;
  logic [NUM_HOLES-1:0] press;

  always_ff @(posedge clk) begin
    if (!reset) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
      btn_s3 <= '0;
      press  <= '0;
    end else begin
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
      btn_s3 <= btn_s2;
      press  <= btn_s2 & ~btn_s3;
    end
  end

  // ---------------------------------------------------------------------
  // Spawn decode. Indices at or beyond NUM_HOLES match no hole and vanish.
  // ---------------------------------------------------------------------
  logic [NUM_HOLES-1:0] spawn_sel;

  always_comb begin
    spawn_sel = '0;
    for (int i = 0; i < NUM_HOLES; i++) begin
      spawn_sel[i] = spawn_valid && (32'(spawn_idx) == i);
    end
  end

  // ---------------------------------------------------------------------
  // Judge.
  // ---------------------------------------------------------------------
  logic [NUM_HOLES-1:0] expired;
  logic [NUM_HOLES-1:0] hit_set;
  logic [NUM_HOLES-1:0] miss_set;
  logic [NUM_HOLES-1:0] hit_clr;
  logic [NUM_HOLES-1:0] spawn_load;
  logic [NUM_HOLES-1:0] timer_clr;
  logic [NUM_HOLES-1:0] mask_next;
  judge_res_e           judge_res;
  judge_res_e           out_res;

  always_comb begin
    hit_set    = press & mole_mask;
    miss_set   = press & ~mole_mask;
    hit_clr    = '0;
    judge_res  = RES_NONE;
    mask_next  = '0;
    spawn_load = '0;

    if (game_active) begin
      if (miss_set != '0) begin
        // A stray press voids the whole cycle: no mole is cleared even if
        // another button in the same cycle landed on one.
        judge_res = RES_MISS;
      end else if (hit_set != '0) begin
        hit_clr = hit_set;
        // Full-clear is decided before spawns land, so a mole raised this
        // cycle cannot downgrade a full clear.
        judge_res = ((mole_mask & ~hit_set & ~expired) == '0) ? RES_FULL : RES_HIT;
      end

      // A hole hit this cycle swallows a same-cycle spawn onto it. A spawn on
      // a hole that is merely expiring keeps the bit and reloads the timer.
      spawn_load = spawn_sel & ~hit_clr;
      mask_next  = (mole_mask & ~hit_clr & ~expired) | spawn_load;
    end
  end

  assign timer_clr = {NUM_HOLES{~game_active}} | hit_clr;

  // ---------------------------------------------------------------------
  // Per-hole lifetime timers.
  // ---------------------------------------------------------------------
  for (genvar g = 0; g < NUM_HOLES; g++) begin : g_timer
    mole_life_timer #(
      .LIFE_W (LIFE_W)
    ) u_timer (
      .clk    (clk),
      .reset  (reset),
      .clear  (timer_clr[g]),
      .load   (spawn_load[g]),
      .life   (mole_life),
      .expire (expired[g])
    );
  end

  // ---------------------------------------------------------------------
  // Optional expiry-as-miss with a saturating pending flag.
  // ---------------------------------------------------------------------
`ifdef EXPIRE_MISS_EN
  logic miss_pend;
  logic miss_pend_next;

  always_comb begin
    out_res        = judge_res;
    miss_pend_next = miss_pend;
    if (!game_active) begin
      miss_pend_next = 1'b0;
    end else if (judge_res == RES_NONE) begin
      // Free slot: drain the parked request and any fresh expiry together.
      if (miss_pend || (expired != '0)) begin
        out_res = RES_MISS;
      end
      miss_pend_next = 1'b0;
    end else if (expired != '0) begin
      miss_pend_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      miss_pend <= 1'b0;
    end else begin
      miss_pend <= miss_pend_next;
    end
  end
`else
  assign out_res = judge_res;
`endif

  // ---------------------------------------------------------------------
  // Registered outputs.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      mole_mask          <= '0;
      miss               <= 1'b0;
      non_full_clear_hit <= 1'b0;
      full_clear_hit     <= 1'b0;
    end else begin
      mole_mask          <= mask_next;
      miss               <= (out_res == RES_MISS);
      non_full_clear_hit <= (out_res == RES_HIT);
      full_clear_hit     <= (out_res == RES_FULL);
    end
  end

endmodule
